bcd_serial_add_ctrl: RTL and testbench

Sequencer that adds two multi-digit packed-BCD operands using one single-digit BCD adder stage, one digit per clock, least significant digit first. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It is the multi-cycle, resource-shared replacement for a wide combinational BCD adder when area matters more than latency.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit_add.sv | 27 ++
 rtl/bcd_serial_add_ctrl.sv | 108 ++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;
  localparam int BCD_CORR    = 6;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with decimal correction and invalid-digit flag.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t da,
  input  bcd_digit_t db,
  input  logic       ci,
  output bcd_digit_t d,
  output logic       co,
  output logic       bad
);

  logic [4:0] s;

  always_comb begin
    s   = {1'b0, da} + {1'b0, db} + {4'b0, ci};
    d   = s[3:0];
    co  = 1'b0;
    // Correction applies to the raw 5-bit sum; only the low nibble is kept.
    if (s > 5'(BCD_MAX)) begin
      d  = s[3:0] + 4'(BCD_CORR);
      co = 1'b1;
    end
    bad = (da > 4'(BCD_MAX)) | (db > 4'(BCD_MAX));
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder: one shared digit stage, LSD first, one digit per clock.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int IDX_W  = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err,
  output logic                  busy
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  state_t              state, state_n;
  logic [IDX_W-1:0]    idx;
  logic                carry;
  logic [4*DIGITS-1:0] a_q, b_q;
  logic                accept;
  logic                last;

  bcd_digit_t          da, db, d;
  logic                co, bad;

  assign da   = a_q[4*idx +: 4];
  assign db   = b_q[4*idx +: 4];
  assign last = (idx == LAST);

  bcd_digit_add u_digit (
    .da  (da),
    .db  (db),
    .ci  (carry),
    .d   (d),
    .co  (co),
    .bad (bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        carry <= cin;
        idx   <= '0;
        sum   <= '0;
        cout  <= 1'b0;
        err   <= 1'b0;
      end else if (state == RUN) begin
        sum[4*idx +: 4] <= d;
        carry           <= co;
        err             <= err | bad;
        idx             <= last ? '0 : idx + 1'b1;
        if (last) cout <= co;
      end
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed and sweep checks for bcd_serial_add_ctrl against a decimal-arithmetic model.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                op_valid;
  logic                op_ready;
  logic [4*DIGITS-1:0] a, b;
  logic                cin;
  logic                res_valid;
  logic                res_ready;
  logic [4*DIGITS-1:0] sum;
  logic                cout;
  logic                err;
  logic                busy;

  int total = 0;
  int bad   = 0;
  int ready_busy_viol = 0;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && op_ready && busy) ready_busy_viol++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned bcd2int(input logic [31:0] v);
    int unsigned r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input int unsigned v);
    logic [31:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc);
    chk("op_ready_idle", op_ready, 1);
    a = ta; b = tb; cin = tc; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int lat = 0;
    while (!res_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(DIGITS));
  endtask

  task automatic finish_op(input string tag);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({tag, "_rv_drop"}, res_valid, 0);
    chk({tag, "_ready_back"}, op_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic [31:0] esum, input logic ecout,
                        input logic eerr);
    start_op(ta, tb, tc);
    wait_done(tag);
    chk({tag, "_sum"}, sum, esum);
    chk({tag, "_cout"}, cout, ecout);
    chk({tag, "_err"}, err, eerr);
    finish_op(tag);
  endtask

  initial begin
    logic [31:0] hs, hsum;
    logic        hcout;
    logic [31:0] ra, rb;
    logic        rc;
    int unsigned tot;

    rst_n = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #3;
    chk("rst_op_ready", op_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("t1", 32'h00000045, 32'h00000038, 1'b0, 32'h00000083, 1'b0, 1'b0);
    run_op("t2a", 32'h99999999, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op("t2b", 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0);
    run_op("t3a", 32'h0000000A, 32'h00000000, 1'b0, 32'h00000010, 1'b0, 1'b1);
    run_op("t3b", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0);

    // Result held in DONE while the consumer stalls; stray op_valid must be ignored.
    start_op(32'h00005678, 32'h00004444, 1'b1);
    wait_done("t4");
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_rv", res_valid, 1);
      chk("t4_hold_sum", sum, 32'h00010123);
      chk("t4_hold_cout", cout, 0);
      chk("t4_hold_ready", op_ready, 0);
      op_valid = (i == 2);
      a = 32'h11111111; b = 32'h11111111;
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    finish_op("t4");
    @(posedge clk); #1;
    chk("t4_no_accept", busy, 0);

    // Asynchronous reset in the middle of RUN.
    start_op(32'h00000045, 32'h00000038, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_partial_sum", sum, 32'h00000083);
    chk("t5_mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", op_ready, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_sum", sum, 0);
    chk("t5_rst_rv", res_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hs = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      hs = hs | 32'(res_valid);
    end
    chk("t5_no_result", hs, 0);
    run_op("t5b", 32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < DIGITS; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      rc    = 1'($urandom_range(0, 1));
      tot   = bcd2int(ra) + bcd2int(rb) + 32'(rc);
      hsum  = int2bcd(tot % 100000000);
      hcout = (tot >= 100000000);
      run_op("rnd", ra, rb, rc, hsum, hcout, 1'b0);
    end

    chk("ready_while_busy", 64'(ready_busy_viol), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
